sprite_pixel_reader: RTL

Consumer side of the sprite tables. It takes the VGA scan coordinates and the active falling piece, reads the matching color index out of the `I_block_h`, `I_block_v` or `O_block` table, and delivers one registered color index per pixel to the color mapper. Piece position and shape are double-buffered and committed only at frame start, so a sprite never tears mid-frame.

---
 rtl/sprite_pixel_reader.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/sprite_pixel_reader.sv
// sprite_pixel_reader: turns the scan coordinate and the active falling piece
// into one registered sprite color index per pixel (2-cycle pipeline).
// Piece position/shape are double-buffered and committed only at frame start.
// Optional build macro: SPRITE_HIT_COUNT_EN adds the per-frame hit counter
// and the hit_count output port.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | no update waiting; active piece in use
// ST_PENDING | a piece update is held in the pending registers
module sprite_pixel_reader #(
    parameter int COORD_W = 10,
    parameter int IDX_W   = 3
) (
    input  logic                              Clk,
    input  logic                              Reset,
    input  logic                              frame_start,
    input  logic                              pix_valid,
    input  logic [COORD_W-1:0]                DrawX,
    input  logic [COORD_W-1:0]                DrawY,
    input  logic [COORD_W-1:0]                piece_x,
    input  logic [COORD_W-1:0]                piece_y,
    input  logic [1:0]                        piece_shape,
    input  logic                              piece_upd,
    input  logic [15:0][63:0][IDX_W-1:0]      I_block_h,
    input  logic [63:0][15:0][IDX_W-1:0]      I_block_v,
    input  logic [31:0][31:0][IDX_W-1:0]      O_block,
    output logic                              piece_ack,
    output logic                              pix_valid_o,
    output logic                              sprite_hit,
`ifdef SPRITE_HIT_COUNT_EN
    output logic [IDX_W-1:0]                  sprite_idx,
    output logic [19:0]                       hit_count
`else
    output logic [IDX_W-1:0]                  sprite_idx
`endif
);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } upd_state_e;

    upd_state_e           state_q, state_d;
    logic [COORD_W-1:0]   pend_x_q, pend_x_d, pend_y_q, pend_y_d;
    logic [1:0]           pend_shape_q, pend_shape_d;
    logic [COORD_W-1:0]   act_x_q, act_x_d, act_y_q, act_y_d;
    logic [1:0]           act_shape_q, act_shape_d;
    logic                 commit;

    // Update FSM: capture requests into pending, commit to active at frame start
    always_comb begin
        state_d      = state_q;
        pend_x_d     = pend_x_q;
        pend_y_d     = pend_y_q;
        pend_shape_d = pend_shape_q;
        act_x_d      = act_x_q;
        act_y_d      = act_y_q;
        act_shape_d  = act_shape_q;
        commit       = 1'b0;
        if (piece_upd && frame_start) begin
            // a request arriving exactly at frame start bypasses the pending stage
            act_x_d     = piece_x;
            act_y_d     = piece_y;
            act_shape_d = piece_shape;
            commit      = 1'b1;
            state_d     = ST_IDLE;
        end else if (piece_upd) begin
            pend_x_d     = piece_x;
            pend_y_d     = piece_y;
            pend_shape_d = piece_shape;
            state_d      = ST_PENDING;
        end else if (frame_start && (state_q == ST_PENDING)) begin
            act_x_d     = pend_x_q;
            act_y_d     = pend_y_q;
            act_shape_d = pend_shape_q;
            commit      = 1'b1;
            state_d     = ST_IDLE;
        end
        piece_ack = commit && !Reset;
    end

    // Update FSM and piece registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            pend_x_q     <= '0;
            pend_y_q     <= '0;
            pend_shape_q <= '0;
            act_x_q      <= '0;
            act_y_q      <= '0;
            act_shape_q  <= '0;
        end else begin
            state_q      <= state_d;
            pend_x_q     <= pend_x_d;
            pend_y_q     <= pend_y_d;
            pend_shape_q <= pend_shape_d;
            act_x_q      <= act_x_d;
            act_y_q      <= act_y_d;
            act_shape_q  <= act_shape_d;
        end
    end

    logic [COORD_W:0] dx_full, dy_full, w_ext, h_ext;
    logic             inb_d;
    logic [5:0]       dx_s1_q, dx_s1_d, dy_s1_q, dy_s1_d;
    logic [1:0]       shape_s1_q, shape_s1_d;
    logic             inb_s1_q, vld_s1_q, vld_s1_d;

    // Stage 1: offset into the piece and bounds test; MSB of the difference is the borrow
    always_comb begin
        dx_full = {1'b0, DrawX} - {1'b0, act_x_q};
        dy_full = {1'b0, DrawY} - {1'b0, act_y_q};
        case (act_shape_q)
            2'd1:    begin w_ext = (COORD_W+1)'(64); h_ext = (COORD_W+1)'(16); end
            2'd2:    begin w_ext = (COORD_W+1)'(16); h_ext = (COORD_W+1)'(64); end
            2'd3:    begin w_ext = (COORD_W+1)'(32); h_ext = (COORD_W+1)'(32); end
            default: begin w_ext = '0;               h_ext = '0;               end
        endcase
        inb_d = (act_shape_q != 2'd0) && !dx_full[COORD_W] && !dy_full[COORD_W]
                && (dx_full < w_ext) && (dy_full < h_ext);
        dx_s1_d    = dx_full[5:0];
        dy_s1_d    = dy_full[5:0];
        shape_s1_d = act_shape_q;
        vld_s1_d   = pix_valid;
    end

    // Stage 1 registers advance every cycle
    always_ff @(posedge Clk) begin
        if (Reset) begin
            dx_s1_q    <= '0;
            dy_s1_q    <= '0;
            shape_s1_q <= '0;
            inb_s1_q   <= 1'b0;
            vld_s1_q   <= 1'b0;
        end else begin
            dx_s1_q    <= dx_s1_d;
            dy_s1_q    <= dy_s1_d;
            shape_s1_q <= shape_s1_d;
            inb_s1_q   <= inb_d;
            vld_s1_q   <= vld_s1_d;
        end
    end

    logic [IDX_W-1:0] entry, idx_q, idx_d;
    logic             hit_q, vld_o_q;

    // Stage 2: table lookup, mirrored so the first-written literal row/column is top-left.
    // Indices use only the bits each table needs, so out-of-bounds offsets stay in range.
    always_comb begin
        case (shape_s1_q)
            2'd1:    entry = I_block_h[4'd15 - dy_s1_q[3:0]][6'd63 - dx_s1_q[5:0]];
            2'd2:    entry = I_block_v[6'd63 - dy_s1_q[5:0]][4'd15 - dx_s1_q[3:0]];
            2'd3:    entry = O_block[5'd31 - dy_s1_q[4:0]][5'd31 - dx_s1_q[4:0]];
            default: entry = '0;
        endcase
        idx_d = inb_s1_q ? entry : '0;
    end

    // Stage 2 output registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            idx_q   <= '0;
            hit_q   <= 1'b0;
            vld_o_q <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            hit_q   <= inb_s1_q;
            vld_o_q <= vld_s1_q;
        end
    end

    assign sprite_idx  = idx_q;
    assign sprite_hit  = hit_q;
    assign pix_valid_o = vld_o_q;

`ifdef SPRITE_HIT_COUNT_EN
    logic [19:0] cnt_q, cnt_d, hc_q, hc_d;
    logic        hit_inc;

    // Per-frame hit counter; a hit on the frame_start cycle belongs to the new frame
    always_comb begin
        hit_inc = vld_o_q && hit_q;
        cnt_d   = cnt_q;
        hc_d    = hc_q;
        if (frame_start) begin
            hc_d  = cnt_q;
            cnt_d = hit_inc ? 20'd1 : 20'd0;
        end else if (hit_inc && (cnt_q != 20'hFFFFF)) begin
            cnt_d = cnt_q + 20'd1;
        end
    end

    // Hit counter registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q <= '0;
            hc_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            hc_q  <= hc_d;
        end
    end

    assign hit_count = hc_q;
`endif

endmodule
